registro_universal: RTL and testbench

Parametrised universal shift register, the N-bit successor of the 4-bit `registro`. It supports serial shift, rotate, parallel load and arithmetic shift in either direction, one step per enabled cycle. It adds a multi-step command that shifts `cnt` positions under a small FSM with `busy`/`done` handshake. It serves as the datapath shifter for the serial/parallel conversion blocks of the design.

---
 rtl/registro_pkg.sv | 14 +
 rtl/registro_paso.sv | 27 ++
 rtl/registro_universal.sv | 106 ++++++++++
 tb/tb_registro_universal.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/registro_pkg.sv
// Shared constants for the universal shift register: operating modes and FSM encoding.
package registro_pkg;

    localparam logic [1:0] MODO_SERIE = 2'b00;
    localparam logic [1:0] MODO_ROT   = 2'b01;
    localparam logic [1:0] MODO_CARGA = 2'b10;
    localparam logic [1:0] MODO_ARIT  = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } estado_t;

endpackage

// File: rtl/registro_paso.sv
// Combinational next value of the register after one step in the selected mode and direction.
module registro_paso
    import registro_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  logic [N-1:0] d,
    input  logic [1:0]   modo,
    input  logic         dir,
    input  logic         s_in,
    output logic [N-1:0] nxt
);

    // dir = 0 moves bits towards the MSB, dir = 1 towards the LSB.
    always_comb begin
        nxt = q;
        case (modo)
            MODO_SERIE: nxt = dir ? {s_in, q[N-1:1]} : {q[N-2:0], s_in};
            MODO_ROT:   nxt = dir ? {q[0], q[N-1:1]} : {q[N-2:0], q[N-1]};
            MODO_CARGA: nxt = d;
            MODO_ARIT:  nxt = dir ? {q[N-1], q[N-1:1]} : {q[N-2:0], 1'b0};
            default:    nxt = q;
        endcase
    end

endmodule

// File: rtl/registro_universal.sv
// N-bit universal shift register with single-step operation and an FSM-driven
// multi-step shift of cnt positions reported through busy/done.
module registro_universal
    import registro_pkg::*;
#(
    parameter  int N  = 8,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          dir,
    input  logic          s_in,
    input  logic [1:0]    modo,
    input  logic [N-1:0]  d,
    input  logic          start,
    input  logic [CW-1:0] cnt,
    output logic [N-1:0]  q,
    output logic          s_out,
    output logic          busy,
    output logic          done
);

    estado_t       state, state_nxt;
    logic [N-1:0]  q_nxt, paso_q;
    logic [CW-1:0] rem, rem_nxt;
    logic [1:0]    modo_l, modo_l_nxt, modo_sel;
    logic          dir_l, dir_l_nxt, dir_sel;
    logic          done_nxt;
    logic          lanza;

    // Handshake: a multi-step command is accepted only in IDLE with enb high;
    // start/modo/dir/cnt are ignored while busy, and done pulses for exactly
    // one cycle after the last step (or right away for cnt = 0).
    assign busy     = (state == ST_SHIFT);
    assign lanza    = (state == ST_IDLE) && enb && start && (modo != MODO_CARGA);
    assign modo_sel = busy ? modo_l : modo;
    assign dir_sel  = busy ? dir_l : dir;
    assign s_out    = dir_sel ? q[0] : q[N-1];

    registro_paso #(.N(N)) u_paso (
        .q    (q),
        .d    (d),
        .modo (modo_sel),
        .dir  (dir_sel),
        .s_in (s_in),
        .nxt  (paso_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (lanza && (cnt != '0)) state_nxt = ST_SHIFT;
            ST_SHIFT: if (enb && (rem == CW'(1))) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        q_nxt      = q;
        rem_nxt    = rem;
        modo_l_nxt = modo_l;
        dir_l_nxt  = dir_l;
        done_nxt   = 1'b0;
        if (state == ST_IDLE) begin
            if (lanza) begin
                // Launch cycle performs no step; cnt = 0 completes immediately.
                if (cnt == '0) begin
                    done_nxt = 1'b1;
                end else begin
                    rem_nxt    = cnt;
                    modo_l_nxt = modo;
                    dir_l_nxt  = dir;
                end
            end else if (enb) begin
                q_nxt = paso_q;
            end
        end else if (enb) begin
            q_nxt   = paso_q;
            rem_nxt = rem - CW'(1);
            if (rem == CW'(1)) done_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= '0;
            rem    <= '0;
            modo_l <= MODO_SERIE;
            dir_l  <= 1'b0;
            done   <= 1'b0;
        end else begin
            q      <= q_nxt;
            rem    <= rem_nxt;
            modo_l <= modo_l_nxt;
            dir_l  <= dir_l_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_registro_universal.sv
// Directed plus randomized bench for registro_universal (N = 8) with a queue-based scoreboard.
module tb_registro_universal;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);
    localparam int W  = 16;

    logic          clk;
    logic          rst;
    logic          enb;
    logic          dir;
    logic          s_in;
    logic [1:0]    modo;
    logic [N-1:0]  d;
    logic          start;
    logic [CW-1:0] cnt;
    logic [N-1:0]  q;
    logic          s_out;
    logic          busy;
    logic          done;

    logic [W-1:0] exp_q[$];
    int           n_vec;
    int           n_err;
    int           ciclos;
    logic [N-1:0] modelo;

    registro_universal #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .enb   (enb),
        .dir   (dir),
        .s_in  (s_in),
        .modo  (modo),
        .d     (d),
        .start (start),
        .cnt   (cnt),
        .q     (q),
        .s_out (s_out),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs);
        logic [W-1:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed %h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic load(input logic [N-1:0] v);
        enb   = 1'b1;
        start = 1'b0;
        modo  = 2'b10;
        d     = v;
        step();
    endtask

    // Launches a multi-step shift and counts cycles until done (bounded).
    task automatic run_multi(input int n, input logic [1:0] m, input logic dr,
                             input int p_from, input int p_len, output int k_out);
        enb   = 1'b1;
        start = 1'b1;
        modo  = m;
        dir   = dr;
        cnt   = CW'(n);
        step();
        start = 1'b0;
        k_out = -1;
        for (int k = 1; k <= 64; k++) begin
            enb = (k >= p_from && k < p_from + p_len) ? 1'b0 : 1'b1;
            step();
            if (done === 1'b1) begin
                k_out = k;
                break;
            end
        end
        enb = 1'b1;
    endtask

    function automatic logic [N-1:0] model_step(input logic [N-1:0] v, input logic [1:0] m,
                                                input logic dr, input logic si,
                                                input logic [N-1:0] dv);
        logic [N-1:0] r;
        case (m)
            2'b00:   r = dr ? ((v >> 1) | (N'(si) << (N - 1))) : ((v << 1) | N'(si));
            2'b01:   r = dr ? ((v >> 1) | (v << (N - 1))) : ((v << 1) | (v >> (N - 1)));
            2'b10:   r = dv;
            default: r = dr ? N'($signed(v) >>> 1) : (v << 1);
        endcase
        return r;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        enb   = 1'b1;
        dir   = 1'b0;
        s_in  = 1'b0;
        modo  = 2'b10;
        d     = 8'hFF;
        start = 1'b0;
        cnt   = '0;
        step();
        step();

        exp_push(16'h0000); check("reset_q", W'(q));
        exp_push(16'h0000); check("reset_busy", W'(busy));
        exp_push(16'h0000); check("reset_done", W'(done));
        exp_push(16'h0000); check("reset_s_out", W'(s_out));
        rst = 1'b0;

        exp_push(16'h00A5); load(8'hA5); check("load_a5", W'(q));
        enb = 1'b0;
        d   = 8'h3C;
        exp_push(16'h00A5); step(); check("hold_1", W'(q));
        exp_push(16'h00A5); step(); check("hold_2", W'(q));

        load(8'h00);
        modo = 2'b00; s_in = 1'b1; dir = 1'b0;
        exp_push(16'h0007);
        repeat (3) step();
        check("serial_left", W'(q));
        load(8'h00);
        modo = 2'b00; s_in = 1'b1; dir = 1'b1;
        exp_push(16'h00E0);
        repeat (3) step();
        check("serial_right", W'(q));
        exp_push(16'h0000); check("serial_right_s_out", W'(s_out));

        load(8'h81);
        modo = 2'b01; dir = 1'b1; cnt = CW'(4); start = 1'b1;
        step();
        exp_push(16'h0001); check("rot_busy_e0", W'(busy));
        exp_push(16'h0081); check("rot_q_e0", W'(q));
        start = 1'b0;
        dir   = 1'b0;
        step();
        exp_push(16'h00C0); check("rot_q_e1", W'(q));
        exp_push(16'h0000); check("rot_s_out_latched_dir", W'(s_out));
        start = 1'b1; modo = 2'b10; cnt = CW'(7); d = 8'h00;
        step();
        exp_push(16'h0060); check("rot_start_ignored_q", W'(q));
        exp_push(16'h0001); check("rot_busy_e2", W'(busy));
        start = 1'b0;
        step();
        exp_push(16'h0001); check("rot_busy_e3", W'(busy));
        exp_push(16'h0000); check("rot_done_e3", W'(done));
        step();
        exp_push(16'h0018); check("rot_result", W'(q));
        exp_push(16'h0000); check("rot_busy_e4", W'(busy));
        exp_push(16'h0001); check("rot_done_e4", W'(done));

        exp_push(16'h0004);
        run_multi(4, 2'b01, 1'b1, 0, 0, ciclos);
        check("restart_in_done_cycles", W'(ciclos));
        exp_push(16'h0081); check("restart_result", W'(q));
        step();
        exp_push(16'h0000); check("done_single_pulse", W'(done));

        load(8'h80);
        exp_push(16'h0003);
        run_multi(3, 2'b11, 1'b1, 0, 0, ciclos);
        check("arit_right_cycles", W'(ciclos));
        exp_push(16'h00F0); check("arit_right_result", W'(q));
        load(8'h81);
        exp_push(16'h0001);
        run_multi(1, 2'b11, 1'b0, 0, 0, ciclos);
        check("arit_left_cycles", W'(ciclos));
        exp_push(16'h0002); check("arit_left_result", W'(q));

        start = 1'b1; modo = 2'b11; cnt = '0;
        step();
        start = 1'b0;
        exp_push(16'h0001); check("cnt0_done", W'(done));
        exp_push(16'h0000); check("cnt0_busy", W'(busy));
        exp_push(16'h0002); check("cnt0_q", W'(q));
        step();
        exp_push(16'h0000); check("cnt0_done_clear", W'(done));
        exp_push(16'h0000); check("cnt0_busy_after", W'(busy));

        load(8'h01);
        exp_push(16'h0007);
        run_multi(5, 2'b01, 1'b0, 2, 2, ciclos);
        check("pause_cycles", W'(ciclos));
        exp_push(16'h0020); check("pause_result", W'(q));

        load(8'h01);
        start = 1'b1; modo = 2'b01; dir = 1'b0; cnt = CW'(6);
        step();
        start = 1'b0;
        step();
        step();
        exp_push(16'h0004); check("abort_pre_q", W'(q));
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_push(16'h0000); check("abort_q", W'(q));
        exp_push(16'h0000); check("abort_busy", W'(busy));
        exp_push(16'h0000); check("abort_done", W'(done));
        for (int i = 0; i < 6; i++) begin
            step();
            exp_push(16'h0000); check("abort_no_done", W'(done));
        end

        modelo = 8'h00;
        for (int i = 0; i < 24; i++) begin
            enb   = 1'b1;
            start = 1'b0;
            modo  = 2'($urandom_range(0, 3));
            dir   = 1'($urandom_range(0, 1));
            s_in  = 1'($urandom_range(0, 1));
            d     = 8'($urandom_range(0, 255));
            modelo = model_step(modelo, modo, dir, s_in, d);
            exp_push(W'(modelo));
            step();
            check("rand_step_q", W'(q));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
